// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch sequencer:
// widths, reset/step defaults, FSM state encoding, alignment helper.
`timescale 1ns/1ps
package fetch_unit_pkg;

    localparam int          XLEN         = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_STEP_DEF  = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_sel.sv
// Next-PC mux: redirect target (word aligned) / pc+step / hold.
// Ports: i_pc, i_advance, i_redirect, i_redirect_pc -> o_next_pc, o_misalign.
`timescale 1ns/1ps
module fetch_pc_sel
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] PC_STEP = PC_STEP_DEF
) (
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_advance,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic [XLEN-1:0] o_next_pc,
    output logic            o_misalign
);

    // Redirect always beats the sequential step.
    always_comb begin
        o_next_pc = i_pc;
        if (i_redirect) begin
            o_next_pc = align_word(i_redirect_pc);
        end else if (i_advance) begin
            o_next_pc = i_pc + PC_STEP;
        end
    end

    assign o_misalign = i_redirect && (i_redirect_pc[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: owns the PC, issues imem req/ack reads,
// hands instr/instr_pc to decode (valid/ready), applies redirects.
`timescale 1ns/1ps
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [XLEN-1:0] PC_STEP  = PC_STEP_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            align_err
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic            r_kill;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_instr_pc;
    logic            r_align_err;

    logic            w_in_req;
    logic            w_take;
    logic [XLEN-1:0] w_pc_nxt;
    logic            w_misalign;

    assign w_in_req = (r_state == S_REQ);
    // Acked word is kept only if it is on the right path and not
    // superseded by a redirect arriving in the same cycle.
    assign w_take   = w_in_req && imem_ack && !r_kill && !redirect;

    fetch_pc_sel #(
        .PC_STEP(PC_STEP)
    ) u_pc_sel (
        .i_pc         (r_pc),
        .i_advance    (w_take),
        .i_redirect   (redirect),
        .i_redirect_pc(redirect_pc),
        .o_next_pc    (w_pc_nxt),
        .o_misalign   (w_misalign)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: w_state_nxt = S_REQ;
            S_REQ:  w_state_nxt = w_take ? S_HOLD : S_REQ;
            S_HOLD: begin
                if (redirect || instr_ready) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_kill      <= 1'b0;
            r_instr     <= '0;
            r_instr_pc  <= '0;
            r_align_err <= 1'b0;
        end else begin
            r_pc        <= w_pc_nxt;
            r_align_err <= r_align_err | w_misalign;
            // The ack retires the in-flight request, so any kill is spent;
            // a redirect with the request still in flight poisons it.
            if (w_in_req) begin
                if (imem_ack) begin
                    r_kill <= 1'b0;
                end else if (redirect) begin
                    r_kill <= 1'b1;
                end
            end
            if (w_take) begin
                r_instr    <= imem_rdata;
                r_instr_pc <= r_pc;
            end
        end
    end

    always_comb begin
        imem_req    = (r_state == S_REQ);
        imem_addr   = r_pc;
        instr_valid = (r_state == S_HOLD);
        instr       = r_instr;
        instr_pc    = r_instr_pc;
        align_err   = r_align_err;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: transaction-level model,
// per-cycle compare, directed scenarios and randomized traffic.
`timescale 1ns/1ps
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        align_err;

    int checks;
    int errors;

    fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_ready(instr_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .align_err  (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: the fetcher is either starting up, waiting on memory for the
    // word at m_pc, or holding one instruction for decode.
    logic        m_started;
    logic        m_have;
    logic        m_stale;
    logic        m_err;
    logic [31:0] m_pc;
    logic [31:0] m_hpc;
    logic [31:0] m_hinstr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_started = 1'b0;
            m_have    = 1'b0;
            m_stale   = 1'b0;
            m_err     = 1'b0;
            m_pc      = 32'h0;
            m_hpc     = 32'h0;
            m_hinstr  = 32'h0;
        end else begin
            if (!m_started) begin
                m_started = 1'b1;
            end else if (m_have) begin
                if (redirect || instr_ready) m_have = 1'b0;
            end else if (imem_ack) begin
                if (m_stale) begin
                    m_stale = 1'b0;
                end else if (!redirect) begin
                    m_have   = 1'b1;
                    m_hpc    = m_pc;
                    m_hinstr = mem_word(m_pc);
                    m_pc     = m_pc + 32'd4;
                end
            end else if (redirect) begin
                m_stale = 1'b1;
            end
            if (redirect) begin
                m_pc = redirect_pc & 32'hFFFF_FFFC;
                if (redirect_pc[1:0] != 2'b00) m_err = 1'b1;
            end
        end
    end

    logic        cmp_en;
    logic [31:0] dq[$];

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("imem_req", {31'b0, imem_req}, {31'b0, m_started && !m_have});
            chk("imem_addr", imem_addr, m_pc);
            chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_have});
            chk("align_err", {31'b0, align_err}, {31'b0, m_err});
            if (m_have) begin
                chk("instr", instr, m_hinstr);
                chk("instr_pc", instr_pc, m_hpc);
            end
        end
        if (rst_n && instr_valid && instr_ready) dq.push_back(instr_pc);
    end

    task automatic tick(input logic a, input logic r, input logic rd,
                        input logic [31:0] rp);
        imem_ack    = a;
        instr_ready = r;
        redirect    = rd;
        redirect_pc = rp;
        @(posedge clk);
        #1;
        redirect = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_req"}, {31'b0, imem_req}, 32'h0);
        chk({tag, "_addr"}, imem_addr, 32'h0);
        chk({tag, "_valid"}, {31'b0, instr_valid}, 32'h0);
        chk({tag, "_instr"}, instr, 32'h0);
        chk({tag, "_ipc"}, instr_pc, 32'h0);
        chk({tag, "_aerr"}, {31'b0, align_err}, 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        reset_checks("rst");
        rst_n = 1'b1;
        dq.delete();
    endtask

    function automatic int count_pc(input logic [31:0] p);
        int n = 0;
        foreach (dq[i]) if (dq[i] == p) n++;
        return n;
    endfunction

    initial begin
        int dly;
        int cnt8;
        int n;
        int guard;
        logic a;
        checks      = 0;
        errors      = 0;
        cmp_en      = 1'b1;
        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        @(posedge clk);
        #1;
        do_reset();

        // Immediate acks except a 3-cycle stall at address 8.
        dly   = 0;
        cnt8  = 0;
        guard = 0;
        while (dq.size() < 4 && guard < 40) begin
            a = 1'b1;
            if (imem_req && imem_addr == 32'h8) begin
                cnt8++;
                if (dly < 3) begin
                    a = 1'b0;
                    dly++;
                end
            end
            tick(a, 1'b1, 1'b0, 32'h0);
            guard++;
        end
        chk("seq_count", dq.size(), 4);
        if (dq.size() >= 4) begin
            chk("seq_pc0", dq[0], 32'h0);
            chk("seq_pc1", dq[1], 32'h4);
            chk("seq_pc2", dq[2], 32'h8);
            chk("seq_pc3", dq[3], 32'hC);
        end
        chk("req8_cycles", cnt8, 4);

        // Decode stall for 4 cycles while holding pc 0x10.
        guard = 0;
        while (!instr_valid && guard < 10) begin
            tick(1'b1, 1'b0, 1'b0, 32'h0);
            guard++;
        end
        chk("hold_reached", {31'b0, instr_valid}, 32'h1);
        n = dq.size();
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0, 1'b0, 32'h0);
            chk("stall_noreq", {31'b0, imem_req}, 32'h0);
            chk("stall_pc", instr_pc, 32'h10);
        end
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        chk("stall_once", dq.size(), n + 1);
        if (dq.size() > 0) chk("stall_last", dq[$], 32'h10);
        chk("resume_addr", imem_addr, 32'h14);

        // Redirect to 0x40 while the request at 0x10 is outstanding.
        do_reset();
        guard = 0;
        while (!(imem_req && imem_addr == 32'h10) && guard < 30) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0);
            guard++;
        end
        chk("at_0x10", imem_addr, 32'h10);
        tick(1'b0, 1'b1, 1'b1, 32'h40);
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        chk("kill_req", {31'b0, imem_req}, 32'h1);
        chk("kill_addr", imem_addr, 32'h40);
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        chk("r40_valid", {31'b0, instr_valid}, 32'h1);
        chk("r40_pc", instr_pc, 32'h40);
        chk("no_0x10", count_pc(32'h10), 0);

        // Misaligned redirect from HOLD with decode consuming.
        tick(1'b0, 1'b1, 1'b1, 32'h83);
        chk("aerr_set", {31'b0, align_err}, 32'h1);
        chk("mis_addr", imem_addr, 32'h80);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        chk("once_0x40", count_pc(32'h40), 1);
        chk("aerr_sticky", {31'b0, align_err}, 32'h1);
        chk("has_0x80", count_pc(32'h80), 1);

        // Wrap from the top of the address space.
        guard = 0;
        while (!instr_valid && guard < 10) begin
            tick(1'b1, 1'b0, 1'b0, 32'h0);
            guard++;
        end
        tick(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        chk("top_addr", imem_addr, 32'hFFFF_FFFC);
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        chk("top_pc", instr_pc, 32'hFFFF_FFFC);
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        chk("pre_rst_addr", imem_addr, 32'h4);

        // Asynchronous reset with a request in flight.
        rst_n = 1'b0;
        #1;
        reset_checks("arst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] rp;
            logic        rd;
            rd = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0: rp = $urandom;
                1: rp = 32'hFFFF_FFF0 | ($urandom_range(0, 15));
                default: rp = {$urandom_range(0, 255), 2'b00};
            endcase
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                tick(1'b0, 1'b0, 1'b0, 32'h0);
                rst_n = 1'b1;
            end else begin
                tick($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                     rd, rp);
            end
        end

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
